shuffle_addr_gen: RTL



---
 rtl/inner_shuffle_pkg.sv | 17 +
 rtl/shuffle_addr_gen_if.sv | 27 ++
 rtl/shuffle_addr_gen.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/inner_shuffle_pkg.sv
// Shared types and sizing helpers for the inner-shuffle address generator.
// Bank index type plus address/counter width functions derived from block shape.
package inner_shuffle_pkg;

    typedef logic bank_t;

    // Address width covering both banks of ROWS*COLS words.
    function automatic int calc_aw(input int rows, input int cols);
        return $clog2(2 * rows * cols);
    endfunction

    // Counter width for a 0..range_n-1 counter, never narrower than one bit.
    function automatic int cnt_w(input int range_n);
        return (range_n <= 2) ? 1 : $clog2(range_n);
    endfunction

endpackage

// File: rtl/shuffle_addr_gen_if.sv
// Input stream, memory write port and memory read-request/beat signals of the shuffle address generator.
// master = upstream/memory side, slave = the address generator.
interface shuffle_addr_gen_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic [WIDTH-1:0] idat;
    logic             ivld;
    logic             irdy;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    wr_addr;
    logic             wr_en;
    logic [AW-1:0]    rd_addr;
    logic             rd_req_vld;
    logic             rd_req_rdy;
    logic             rd_beat;

    modport master (
        output idat, ivld, rd_req_rdy, rd_beat,
        input  irdy, wr_data, wr_addr, wr_en, rd_addr, rd_req_vld
    );

    modport slave (
        input  idat, ivld, rd_req_rdy, rd_beat,
        output irdy, wr_data, wr_addr, wr_en, rd_addr, rd_req_vld
    );
endinterface

// File: rtl/shuffle_addr_gen.sv
// Double-buffered transpose address generator: row-major writes, column-major read requests.
// Write path is zero latency; a bank is recycled only after all its read beats have retired.
module shuffle_addr_gen
    import inner_shuffle_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROWS  = 2,
    parameter int COLS  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    shuffle_addr_gen_if.slave bus
);
    localparam int N   = ROWS * COLS;
    localparam int AW  = calc_aw(ROWS, COLS);
    localparam int WCW = cnt_w(N);
    localparam int RW  = cnt_w(ROWS);
    localparam int CW  = cnt_w(COLS);

    localparam logic [AW-1:0]  N_A    = AW'(N);
    localparam logic [AW-1:0]  COLS_A = AW'(COLS);
    localparam logic [WCW-1:0] W_LAST = WCW'(N - 1);
    localparam logic [WCW-1:0] ROWS_W = WCW'(ROWS);
    localparam logic [RW-1:0]  R_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0]  C_LAST = CW'(COLS - 1);

    bank_t          wbank_q, wbank_d, rbank_q, rbank_d, retire_bank_q, retire_bank_d;
    logic [WCW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [RW-1:0]  r_q, r_d;
    logic [CW-1:0]  c_q, c_d;
    logic [1:0]     full_q, full_d, issued_q, issued_d;

    logic           wr_fire, wr_last, rd_fire, rd_last, beat_legal, beat_ok, ret_last;
    logic [WCW-1:0] iss_cnt;

    assign bus.irdy       = rst_n && !full_q[wbank_q];
    assign bus.wr_en      = bus.ivld && bus.irdy;
    assign bus.wr_data    = bus.idat;
    assign bus.wr_addr    = (wbank_q ? N_A : '0) + AW'(wcnt_q);
    assign bus.rd_req_vld = full_q[rbank_q] && !issued_q[rbank_q];
    assign bus.rd_addr    = (rbank_q ? N_A : '0) + AW'(r_q) * COLS_A + AW'(c_q);

    assign wr_fire = bus.wr_en;
    assign wr_last = wr_fire && (wcnt_q == W_LAST);
    assign rd_fire = bus.rd_req_vld && bus.rd_req_rdy;
    assign rd_last = rd_fire && (r_q == R_LAST) && (c_q == C_LAST);

    // A beat is legal once its word has been requested: either the retiring bank is
    // fully issued, or it is the bank being issued and has more requests out than beats.
    assign iss_cnt    = WCW'(c_q) * ROWS_W + WCW'(r_q);
    assign beat_legal = issued_q[retire_bank_q] ||
                        ((retire_bank_q == rbank_q) && full_q[rbank_q] && (iss_cnt > rcnt_q));
    assign beat_ok    = bus.rd_beat && beat_legal;
    assign ret_last   = beat_ok && (rcnt_q == W_LAST);

    always_comb begin
        wcnt_d  = wcnt_q;
        wbank_d = wbank_q;
        if (wr_last) begin
            wcnt_d  = '0;
            wbank_d = ~wbank_q;
        end else if (wr_fire) begin
            wcnt_d = wcnt_q + WCW'(1);
        end
    end

    always_comb begin
        r_d     = r_q;
        c_d     = c_q;
        rbank_d = rbank_q;
        if (rd_fire) begin
            if (r_q == R_LAST) begin
                r_d = '0;
                if (c_q == C_LAST) begin
                    c_d     = '0;
                    rbank_d = ~rbank_q;
                end else begin
                    c_d = c_q + CW'(1);
                end
            end else begin
                r_d = r_q + RW'(1);
            end
        end
    end

    always_comb begin
        rcnt_d        = rcnt_q;
        retire_bank_d = retire_bank_q;
        if (ret_last) begin
            rcnt_d        = '0;
            retire_bank_d = ~retire_bank_q;
        end else if (beat_ok) begin
            rcnt_d = rcnt_q + WCW'(1);
        end
    end

    // Set and clear never hit the same bank in one cycle: a full bank blocks writes.
    always_comb begin
        full_d   = full_q;
        issued_d = issued_q;
        if (wr_last)  full_d[wbank_q]         = 1'b1;
        if (rd_last)  issued_d[rbank_q]       = 1'b1;
        if (ret_last) begin
            full_d[retire_bank_q]   = 1'b0;
            issued_d[retire_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q  <= '0;
            wbank_q <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            wbank_q <= wbank_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            c_q     <= '0;
            rbank_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            c_q     <= c_d;
            rbank_q <= rbank_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q        <= '0;
            retire_bank_q <= 1'b0;
        end else begin
            rcnt_q        <= rcnt_d;
            retire_bank_q <= retire_bank_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            issued_q <= '0;
        end else begin
            full_q   <= full_d;
            issued_q <= issued_d;
        end
    end

    ap_beat_legal: assert property (@(posedge clk) disable iff (!rst_n)
        bus.rd_beat |-> beat_legal)
        else $error("rd_beat with no outstanding read request");

endmodule
